// File: rtl/mips_fetch_unit.sv
// MIPS instruction fetch unit: in-order request/response fetch into a small
// instruction queue with redirect support. Optional bypass: MIPS_FETCH_BYPASS_EN.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [31:0]   qdata_q [QDEPTH];
    logic [31:0]   qpc_q   [QDEPTH];

    logic [CW:0] occ;
    logic        req_fire, resp_take, resp_live, q_valid, push, pop, byp;

    always_comb begin
        occ            = {1'b0, count_q} + {1'b0, outst_q};
        imem_req_valid = !reset && !redirect_valid && (occ < QD);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_take      = !reset && imem_resp_valid;
        resp_live      = resp_take && (drop_q == '0) && !redirect_valid;
        q_valid        = (count_q != '0);
        pop            = !reset && q_valid && inst_ready && !redirect_valid;
`ifdef MIPS_FETCH_BYPASS_EN
        // Empty queue: hand the response straight to decode; only queue it if decode stalls.
        byp            = resp_live && !q_valid;
        push           = resp_live && !(byp && inst_ready);
        inst_valid     = !reset && (q_valid || byp);
        inst_data      = byp ? imem_resp_data : qdata_q[head_q];
        inst_pc        = byp ? resp_pc_q : qpc_q[head_q];
`else
        byp            = 1'b0;
        push           = resp_live;
        inst_valid     = !reset && q_valid;
        inst_data      = qdata_q[head_q];
        inst_pc        = qpc_q[head_q];
`endif
    end

    always_comb begin
        fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = resp_live ? resp_pc_q + 32'd4 : resp_pc_q;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_take);
        drop_d     = (resp_take && drop_q != '0) ? drop_q - 1'b1 : drop_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        head_d     = pop  ? head_q + 1'b1 : head_q;
        tail_d     = push ? tail_q + 1'b1 : tail_q;
        if (redirect_valid) begin
            // Everything still in flight belongs to the old path and must be dropped.
            fetch_pc_d = redirect_pc & ~32'h3;
            resp_pc_d  = redirect_pc & ~32'h3;
            drop_d     = outst_q - CW'(resp_take);
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC & ~32'h3;
            resp_pc_q  <= RESET_PC & ~32'h3;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            qdata_q[tail_q] <= imem_resp_data;
            qpc_q[tail_q]   <= resp_pc_q;
        end
    end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit against an epoch-tagged stream model.
module tb_mips_fetch_unit;
    localparam int          QD   = 4;
    localparam logic [31:0] RPC  = 32'h00000000;
`ifdef MIPS_FETCH_BYPASS_EN
    localparam bit          BYP  = 1'b1;
`else
    localparam bit          BYP  = 1'b0;
`endif
    localparam int          NCYC = 3000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;

    mips_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;

    mreq_t       memq[$];
    inst_t       mq[$];
    logic [31:0] m_fetch;
    int          epoch;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h24020005;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        bit          r_rst, r_rdy, r_redir, r_iready, live, ex_req, ex_iv, resp_v, resp_cur;
        logic [31:0] r_tgt, ex_pc, ex_data;
        mreq_t       rh, nr;
        int          lat, last_due;

        reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        m_fetch = RPC; epoch = 0; last_due = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            r_rst = (cyc < 4); r_rdy = 1'b1; r_redir = 1'b0; r_iready = 1'b1;
            r_tgt = $urandom; lat = 0;
            if (cyc >= 200 && cyc < 212) r_iready = 1'b0;          // decode stall fills queue
            else if (cyc == 212) begin r_iready = 1'b0; r_redir = 1'b1; r_tgt = 32'h00000402; end
            else if (cyc == 300 || cyc == 301) begin r_redir = 1'b1; r_tgt = 32'h00000800 + 32'(cyc); end
            else if (cyc == 400) r_rst = 1'b1;
            else if (cyc > 450) begin
                r_rdy    = ($urandom_range(3, 0) != 0);
                r_iready = ($urandom_range(9, 0) < 7);
                r_redir  = ($urandom_range(29, 0) == 0);
                r_rst    = ($urandom_range(199, 0) == 0);
                lat      = $urandom_range(2, 0);
            end

            resp_cur = !r_rst && memq.size() > 0 && memq[0].due <= cyc;
            if (resp_cur) rh = memq[0];
            resp_v   = r_rst ? 1'($urandom_range(1, 0)) : resp_cur;

            reset           = r_rst;
            imem_req_ready  = r_rdy;
            redirect_valid  = r_redir;
            redirect_pc     = r_tgt;
            inst_ready      = r_iready;
            imem_resp_valid = resp_v;
            imem_resp_data  = resp_cur ? dfun(rh.addr) : $urandom;
            #1;

            live   = resp_cur && rh.ep == epoch && !r_redir;
            ex_req = !r_rst && !r_redir && (mq.size() + memq.size() < QD);
            ex_iv  = !r_rst && (mq.size() > 0 || (BYP && live));
            if (mq.size() > 0) begin ex_pc = mq[0].pc; ex_data = mq[0].data; end
            else begin ex_pc = rh.addr; ex_data = dfun(rh.addr); end

            chk("req_valid", 32'(imem_req_valid), 32'(ex_req));
            if (ex_req) chk("req_addr", imem_req_addr, m_fetch);
            chk("inst_valid", 32'(inst_valid), 32'(ex_iv));
            if (ex_iv && inst_valid) begin
                chk("inst_pc", inst_pc, ex_pc);
                chk("inst_data", inst_data, ex_data);
            end

            if (r_rst) begin
                memq.delete(); mq.delete();
                m_fetch = RPC & ~32'h3; epoch++; last_due = 0;
            end else begin
                if (resp_cur) void'(memq.pop_front());
                if (r_redir) begin
                    mq.delete(); epoch++;
                    m_fetch = r_tgt & ~32'h3;
                end else begin
                    if (ex_iv && r_iready) begin
                        if (mq.size() > 0) void'(mq.pop_front());
                        else live = 1'b0;                      // bypassed straight to decode
                    end
                    if (live) mq.push_back('{pc: rh.addr, data: dfun(rh.addr)});
                end
                if (ex_req && r_rdy) begin
                    nr.addr = m_fetch; nr.ep = epoch;
                    nr.due  = (cyc + 1 + lat > last_due) ? cyc + 1 + lat : last_due;
                    last_due = nr.due;
                    memq.push_back(nr);
                    m_fetch += 32'd4;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
